// File: rtl/data_mem_pkg.sv
// Shared definitions for the data memory: Funct3 access codes, the
// clear/idle state encoding and the byte-write mask helper.
package dmem_pkg;

  // RV32I load/store width codes carried on Funct3
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } dmem_state_t;

  // Byte lanes touched by a store of the given width at the given byte offset.
  // Codes other than SB/SH/SW yield an empty mask, so the store is dropped.
  function automatic logic [3:0] byte_mask(input logic [2:0] funct3,
                                           input logic [1:0] offset);
    logic [3:0] m;
    m = 4'b0000;
    case (funct3)
      F3_B:    m = 4'b0001 << offset;
      F3_H:    m = offset[1] ? 4'b1100 : 4'b0011;
      F3_W:    m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/data_mem_if.sv
// Core <-> data memory bus. The Fault wire exists only when the memory is
// built with DMEM_FAULT_EN defined.
interface data_mem_if;

  logic        MemWrite;
  logic        MemRead;
  logic [2:0]  Funct3;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Ready;
`ifdef DMEM_FAULT_EN
  logic        Fault;

  modport master (
    output MemWrite, MemRead, Funct3, Addr, WriteData,
    input  ReadData, Ready, Fault
  );

  modport slave (
    input  MemWrite, MemRead, Funct3, Addr, WriteData,
    output ReadData, Ready, Fault
  );
`else
  modport master (
    output MemWrite, MemRead, Funct3, Addr, WriteData,
    input  ReadData, Ready
  );

  modport slave (
    input  MemWrite, MemRead, Funct3, Addr, WriteData,
    output ReadData, Ready
  );
`endif

endinterface

// File: rtl/data_mem_load_extend.sv
// Load-path formatter: picks the addressed byte/half out of a memory word and
// sign- or zero-extends it to 32 bits. Purely combinational.
module load_extend
  import dmem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_offset,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane selection followed by width/sign extension
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    w_byte = i_word[{i_offset, 3'b000} +: 8];
    w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];
    o_data = i_word;
    case (i_funct3)
      F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_data = {24'h000000, w_byte};
      F3_H:    o_data = {{16{w_half[15]}}, w_half};
      F3_HU:   o_data = {16'h0000, w_half};
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/data_mem.sv
// Word-organised RV32I data memory with combinational reads, byte-lane
// writes and a post-reset clear sequence that zeroes the array before Ready.
// Optional feature: define DMEM_FAULT_EN to flag and suppress misaligned or
// out-of-range accesses; without it upper address bits simply alias.
module data_mem
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic     clk,
  input  logic     rst_n,
  data_mem_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);

  dmem_state_t   r_state;
  dmem_state_t   w_state_next;
  logic [AW-1:0] r_clr_ptr;
  logic [31:0]   r_mem [DEPTH_WORDS];

  logic [AW-1:0] w_index;
  logic [1:0]    w_offset;
  logic          w_ready;
  logic          w_fault;
  logic [31:0]   w_rd_word;
  logic [31:0]   w_ld_data;
  logic [31:0]   w_store_data;
  logic          w_mem_we;
  logic [AW-1:0] w_mem_idx;
  logic [3:0]    w_mem_be;
  logic [31:0]   w_mem_wdata;

  assign w_index  = bus.Addr[AW+1:2];
  assign w_offset = bus.Addr[1:0];

`ifdef DMEM_FAULT_EN
  logic w_misalign;
  logic w_out_of_range;

  // Alignment and range check on the current access
  always_comb begin
    w_misalign     = 1'b0;
    w_out_of_range = |bus.Addr[31:AW+2];
    case (bus.Funct3)
      F3_H, F3_HU: w_misalign = bus.Addr[0];
      F3_W:        w_misalign = (bus.Addr[1:0] != 2'b00);
      default:     w_misalign = 1'b0;
    endcase
    w_fault = w_ready && (bus.MemRead || bus.MemWrite) &&
              (w_misalign || w_out_of_range);
  end

  assign bus.Fault = w_fault;
`else
  logic w_unused_addr;

  // Upper address bits are deliberately ignored so accesses alias
  assign w_unused_addr = ^bus.Addr[31:AW+2];
  assign w_fault       = 1'b0;
`endif

  // State register and clear pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= CLEAR;
      r_clr_ptr <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      r_state <= w_state_next;
      if (r_state == CLEAR) begin
        r_clr_ptr <= r_clr_ptr + AW'(1);
      end
    end
  end

  // Next state: leave CLEAR once the last word has been zeroed
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      CLEAR:   if (r_clr_ptr == AW'(DEPTH_WORDS - 1)) w_state_next = IDLE;
      IDLE:    w_state_next = IDLE;
      default: w_state_next = CLEAR;
    endcase
  end

  // Outputs: write-port steering, Ready and load data
  always_comb begin
    w_ready      = (r_state == IDLE);
    w_mem_we     = 1'b0;
    w_mem_idx    = w_index;
    w_mem_be     = 4'b0000;
    w_mem_wdata  = '0;
    w_store_data = bus.WriteData;
    case (bus.Funct3)
      F3_B:    w_store_data = {4{bus.WriteData[7:0]}};
      F3_H:    w_store_data = {2{bus.WriteData[15:0]}};
      default: w_store_data = bus.WriteData;
    endcase
    case (r_state)
      CLEAR: begin
        w_mem_we    = 1'b1;
        w_mem_idx   = r_clr_ptr;
        w_mem_be    = 4'b1111;
        w_mem_wdata = '0;
      end
      IDLE: begin
        w_mem_we    = bus.MemWrite && !w_fault;
        w_mem_idx   = w_index;
        w_mem_be    = byte_mask(bus.Funct3, w_offset);
        w_mem_wdata = w_store_data;
      end
      default: w_mem_we = 1'b0;
    endcase
    // A clock edge that coincides with reset assertion must not commit
    w_mem_we = w_mem_we && rst_n;
  end

  // Byte-lane writes into the array
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset term; the CLEAR sequence zeroes it instead.
    if (w_mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_mem_be[i]) r_mem[w_mem_idx][8*i +: 8] <= w_mem_wdata[8*i +: 8];
      end
    end
  end

  assign w_rd_word = r_mem[w_index];

  load_extend u_load_extend (
    .i_word   (w_rd_word),
    .i_funct3 (bus.Funct3),
    .i_offset (w_offset),
    .o_data   (w_ld_data)
  );

  assign bus.Ready    = w_ready;
  assign bus.ReadData = (w_ready && bus.MemRead && !w_fault) ? w_ld_data : 32'h0;

endmodule

// File: tb/tb_data_mem.sv
// Scoreboard bench for data_mem (DEPTH_WORDS=16). Stimulus drives the bus
// just after each rising edge and queues the expected response; a monitor
// checks everything queued on the following falling edge.
module tb_data_mem;
  import dmem_pkg::*;

  localparam int DEPTH = 16;

  typedef enum {K_RDATA, K_READY, K_FAULT} kind_t;
  typedef struct {
    string       name;
    kind_t       kind;
    logic [31:0] exp;
  } item_t;

  logic  clk;
  logic  rst_n;
  item_t sb_q[$];
  int    checks;
  int    failures;

  data_mem_if bus ();

  data_mem #(.DEPTH_WORDS(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    bus.MemRead   = rd;
    bus.MemWrite  = wr;
    bus.Funct3    = f3;
    bus.Addr      = a;
    bus.WriteData = wd;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string n, input kind_t k, input logic [31:0] e);
    item_t it;
    it.name = n;
    it.kind = k;
    it.exp  = e;
    sb_q.push_back(it);
  endtask

  // Called right after rst_n is released: Ready must stay low for DEPTH-1
  // edges and rise on edge DEPTH; ReadData stays 0 throughout.
  task automatic clear_sequence(input string tag);
    push({tag, "_ready_e0"}, K_READY, 32'd0);
    for (int k = 1; k <= DEPTH; k++) begin
      cyc();
      push($sformatf("%s_ready_e%0d", tag, k), K_READY, (k == DEPTH) ? 32'd1 : 32'd0);
      push($sformatf("%s_rdata_e%0d", tag, k), K_RDATA, 32'd0);
    end
  endtask

  // Monitor: compare every queued expectation against the live outputs
  initial begin
    item_t       it;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0) begin
        it  = sb_q.pop_front();
        act = '0;
        case (it.kind)
          K_RDATA: act = bus.ReadData;
          K_READY: act = {31'b0, bus.Ready};
`ifdef DMEM_FAULT_EN
          K_FAULT: act = {31'b0, bus.Fault};
`endif
          default: act = 'x;
        endcase
        checks++;
        if (act !== it.exp) begin
          failures++;
          $display("FAIL %s: got %h expected %h", it.name, act, it.exp);
        end
      end
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    drive(1'b1, 1'b0, F3_W, 32'h0000_003C, 32'h0);
    cyc();
    push("reset_ready", K_READY, 32'd0);
    push("reset_rdata", K_RDATA, 32'd0);
`ifdef DMEM_FAULT_EN
    push("reset_fault", K_FAULT, 32'd0);
`endif
    cyc();
    rst_n = 1'b1;
    clear_sequence("init");

    // LW from the last word after clearing
    drive(1'b1, 1'b0, F3_W, 32'h0000_003C, 32'h0);
    push("lw_3c_cleared", K_RDATA, 32'h0000_0000);
    cyc();

    // SW then loads of every width
    drive(1'b0, 1'b1, F3_W, 32'h0000_0010, 32'hDEAD_BEEF);
    cyc();
    drive(1'b1, 1'b0, F3_W, 32'h0000_0010, 32'h0);
    push("lw_10", K_RDATA, 32'hDEAD_BEEF);
    cyc();
    drive(1'b1, 1'b0, F3_B, 32'h0000_0010, 32'h0);
    push("lb_10", K_RDATA, 32'hFFFF_FFEF);
    cyc();
    drive(1'b1, 1'b0, F3_B, 32'h0000_0011, 32'h0);
    push("lb_11", K_RDATA, 32'hFFFF_FFBE);
    cyc();
    drive(1'b1, 1'b0, F3_BU, 32'h0000_0013, 32'h0);
    push("lbu_13", K_RDATA, 32'h0000_00DE);
    cyc();
    drive(1'b1, 1'b0, F3_BU, 32'h0000_0012, 32'h0);
    push("lbu_12", K_RDATA, 32'h0000_00AD);
    cyc();
    drive(1'b1, 1'b0, F3_H, 32'h0000_0012, 32'h0);
    push("lh_12", K_RDATA, 32'hFFFF_DEAD);
    cyc();
    drive(1'b1, 1'b0, F3_HU, 32'h0000_0010, 32'h0);
    push("lhu_10", K_RDATA, 32'h0000_BEEF);
    cyc();
    drive(1'b0, 1'b0, F3_W, 32'h0000_0010, 32'h0);
    push("no_read_zero", K_RDATA, 32'h0000_0000);
    cyc();

    // Partial stores: SB lane 1 then SH upper half of 0x11223344
    drive(1'b0, 1'b1, F3_W, 32'h0000_0020, 32'h1122_3344);
    cyc();
    drive(1'b0, 1'b1, F3_B, 32'h0000_0021, 32'hFFFF_FFAA);
    cyc();
    drive(1'b0, 1'b1, F3_H, 32'h0000_0022, 32'hFFFF_5566);
    cyc();
    drive(1'b1, 1'b0, F3_W, 32'h0000_0020, 32'h0);
    push("lw_20_merged", K_RDATA, 32'h5566_AA44);
    cyc();

    // Unused store code must not write; unused load code returns full word
    drive(1'b0, 1'b1, 3'b011, 32'h0000_0020, 32'hFFFF_FFFF);
    cyc();
    drive(1'b1, 1'b0, 3'b110, 32'h0000_0020, 32'h0);
    push("ld_unused_f3", K_RDATA, 32'h5566_AA44);
    cyc();

    // Same-cycle read and write: old data now, new data next cycle
    drive(1'b0, 1'b1, F3_W, 32'h0000_0008, 32'h1234_5678);
    cyc();
    drive(1'b1, 1'b1, F3_W, 32'h0000_0008, 32'hCAFE_F00D);
    push("rw_same_cycle_old", K_RDATA, 32'h1234_5678);
    cyc();
    drive(1'b1, 1'b0, F3_W, 32'h0000_0008, 32'h0);
    push("rw_next_cycle_new", K_RDATA, 32'hCAFE_F00D);
    cyc();

`ifdef DMEM_FAULT_EN
    drive(1'b0, 1'b1, F3_W, 32'h0000_0022, 32'h0000_0000);
    push("sw_22_fault", K_FAULT, 32'd1);
    cyc();
    drive(1'b1, 1'b0, F3_W, 32'h0000_0020, 32'h0);
    push("lw_20_unchanged", K_RDATA, 32'h5566_AA44);
    push("lw_20_no_fault", K_FAULT, 32'd0);
    cyc();
    drive(1'b1, 1'b0, F3_H, 32'h0000_0011, 32'h0);
    push("lh_11_fault", K_FAULT, 32'd1);
    push("lh_11_rdata", K_RDATA, 32'h0);
    cyc();
    drive(1'b1, 1'b0, F3_W, 32'h0000_1000, 32'h0);
    push("lw_1000_fault", K_FAULT, 32'd1);
    push("lw_1000_rdata", K_RDATA, 32'h0);
    cyc();
`else
    // Aliasing and misaligned accesses without the fault check
    drive(1'b1, 1'b0, F3_W, 32'h0000_1010, 32'h0);
    push("lw_1010_alias", K_RDATA, 32'hDEAD_BEEF);
    cyc();
    drive(1'b1, 1'b0, F3_H, 32'h0000_0013, 32'h0);
    push("lh_13_misaligned", K_RDATA, 32'hFFFF_DEAD);
    cyc();
    drive(1'b1, 1'b0, F3_W, 32'h0000_0022, 32'h0);
    push("lw_22_misaligned", K_RDATA, 32'h5566_AA44);
    cyc();
`endif

    // Reset, then a one-cycle reset pulse at clear step 7
    drive(1'b1, 1'b0, F3_W, 32'h0000_0010, 32'h0);
    rst_n = 1'b0;
    push("rst2_ready", K_READY, 32'd0);
    push("rst2_rdata", K_RDATA, 32'd0);
    cyc();
    rst_n = 1'b1;
    for (int k = 1; k <= 7; k++) cyc();
    rst_n = 1'b0;
    push("midclear_ready", K_READY, 32'd0);
    cyc();
    rst_n = 1'b1;
    clear_sequence("reclear");
    drive(1'b1, 1'b0, F3_W, 32'h0000_0010, 32'h0);
    push("lw_10_after_clear", K_RDATA, 32'h0000_0000);
    cyc();
    drive(1'b1, 1'b0, F3_W, 32'h0000_0008, 32'h0);
    push("lw_08_after_clear", K_RDATA, 32'h0000_0000);
    cyc();
    drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) cyc();
    if (sb_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
